// File: rtl/adc_sample_buffer.sv
// Elastic sample buffer for one ADC channel: a small FIFO that waits for a
// priming level, then streams one sample per cycle with a valid strobe.
// Overflow (dropped write) and underflow (ran dry while streaming) are sticky.
module adc_sample_buffer #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DATA_W-1:0]          din,
  input  logic                       din_valid,
  input  logic                       dout_ready,
  output logic [DATA_W-1:0]          dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       streaming,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRIME_CNT = (AW+1)'(PRIME_LEVEL);

  typedef enum logic {PRIME, STREAM} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, we, re, underflow_evt;

  // Full/empty come from the registered count, so a read in the same cycle
  // never frees a slot for a write into a full FIFO.
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign we        = din_valid & ~full;
  assign re        = (state == STREAM) & dout_ready & ~empty;
  assign level     = count;
  assign streaming = (state == STREAM);

  // Next-state logic: prime until enough words are buffered, fall back when
  // the consumer wants data and there is none.
  always_comb begin
    state_next    = state;
    underflow_evt = 1'b0;
    case (state)
      PRIME: begin
        if (count >= PRIME_CNT) state_next = STREAM;
      end
      STREAM: begin
        if (empty && dout_ready) begin
          underflow_evt = 1'b1;
          state_next    = PRIME;
        end
      end
      default: state_next = PRIME;
    endcase
  end

  // Sample storage; contents are not cleared by reset since pointers are.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= din;
  end

  // Control: pointers, occupancy, state and sticky flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= PRIME;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_next;
      if (we) wr_ptr <= wr_ptr + AW'(1);
      if (re) rd_ptr <= rd_ptr + AW'(1);
      case ({we, re})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (din_valid && full) overflow  <= 1'b1;
      if (underflow_evt)     underflow <= 1'b1;
    end
  end

  // Output register: valid one cycle after a read is issued, data held otherwise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= re;
      if (re) dout <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Scoreboard bench for adc_sample_buffer: stimulus pushes hand-derived output
// sequences into a queue, a monitor pops and compares on every dout_valid.
module tb_adc_sample_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [4:0]        level;
  logic              streaming;
  logic              overflow;
  logic              underflow;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];

  adc_sample_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PRIME_LEVEL(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .din        (din),
    .din_valid  (din_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .level      (level),
    .streaming  (streaming),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every presented sample must be the next expected one.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_dout: got %0d expected none", dout);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(dout) != e) begin
          miscompares++;
          $display("FAIL dout: got %0d expected %0d", dout, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    tick(); tick();
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_level", level, 0);
    check("rst_streaming", streaming, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);

    // Steady stream, then input stops and the buffer drains to underflow.
    rstn = 1'b1;
    for (int k = 1; k <= 12; k++) exp_q.push_back(k);
    for (int k = 0; k < 12; k++) begin
      din = DATA_W'(k + 1); din_valid = 1'b1;
      tick();
      if (k == 3) begin
        check("prime_level4", level, 4);
        check("prime_not_streaming", streaming, 0);
      end
      if (k == 4) check("prime_streaming", streaming, 1);
      if (k == 5) begin
        check("first_valid", dout_valid, 1);
        check("first_dout", dout, 1);
      end
      if (k == 9) check("steady_level", level, 5);
    end
    check("steady_no_overflow", overflow, 0);
    check("steady_no_underflow", underflow, 0);
    din_valid = 1'b0;
    repeat (8) tick();
    check("drain_underflow", underflow, 1);
    check("drain_streaming", streaming, 0);
    check("drain_level", level, 0);
    check("drain_valid", dout_valid, 0);
    check("drain_overflow", overflow, 0);

    // Resume: four new words re-prime, one transition cycle, then output.
    for (int k = 0; k < 4; k++) exp_q.push_back(100 + k);
    for (int k = 0; k < 4; k++) begin
      din = DATA_W'(100 + k); din_valid = 1'b1;
      tick();
    end
    check("reprime_not_streaming", streaming, 0);
    check("reprime_level", level, 4);
    din_valid = 1'b0;
    tick();
    check("reprime_streaming", streaming, 1);
    check("reprime_no_valid_yet", dout_valid, 0);
    repeat (8) tick();
    check("reprime_drained", level, 0);
    check("reprime_back_to_prime", streaming, 0);

    // Overflow: no reads while 20 words arrive; 17..20 are dropped.
    rstn = 1'b0; tick(); rstn = 1'b1;
    check("ovf_rst_overflow", overflow, 0);
    check("ovf_rst_underflow", underflow, 0);
    dout_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      din = DATA_W'(k + 1); din_valid = 1'b1;
      tick();
    end
    for (int k = 1; k <= 16; k++) exp_q.push_back(k);
    check("ovf_level", level, 16);
    check("ovf_flag", overflow, 1);
    check("ovf_streaming", streaming, 1);
    check("ovf_no_valid", dout_valid, 0);
    check("ovf_stall_no_underflow", underflow, 0);
    din_valid = 1'b0; dout_ready = 1'b1;
    repeat (20) tick();
    check("ovf_drain_underflow", underflow, 1);
    check("ovf_drain_streaming", streaming, 0);

    // Toggling ready across pointer wrap: the FIFO fills at edge 25, after
    // which every write landing on a read edge (even k >= 26) is refused.
    rstn = 1'b0; tick(); rstn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      din = DATA_W'(k + 1); din_valid = 1'b1;
      dout_ready = (k % 2 == 0);
      if (k <= 25 || (k % 2 == 1)) exp_q.push_back(k + 1);
      tick();
    end
    check("toggle_level", level, 16);
    check("toggle_overflow", overflow, 1);
    din_valid = 1'b0; dout_ready = 1'b1;
    repeat (24) tick();
    check("toggle_drain_level", level, 0);
    check("toggle_underflow", underflow, 1);

    // Reset mid-stream with level 5; old words must never reappear.
    for (int k = 0; k < 3; k++) exp_q.push_back(201 + k);
    for (int k = 0; k < 8; k++) begin
      din = DATA_W'(201 + k); din_valid = 1'b1;
      tick();
    end
    check("mid_level", level, 5);
    rstn = 1'b0;
    din = DATA_W'(209);
    tick();
    check("mid_rst_level", level, 0);
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_underflow", underflow, 0);
    check("mid_rst_streaming", streaming, 0);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(300 + k);
    for (int k = 0; k < 4; k++) begin
      din = DATA_W'(300 + k); din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    repeat (10) tick();
    check("mid_final_level", level, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
